// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - ReqSize encodings (byte / half / word / illegal)
//   - FSM state enum for the sub-word read-modify-write sequence
//   - is_misaligned(): alignment / legality rule for a request
// -----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_IDLE      = 1'b0,  // accepting requests
        ST_RMW_WRITE = 1'b1   // writing the merged word of a sub-word store
    } lsu_state_e;

    // A half must sit on an even byte address and a word on a multiple of
    // four; the reserved size code is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SIZE_BYTE: bad = 1'b0;
            SIZE_HALF: bad = offset[0];
            SIZE_WORD: bad = (offset != 2'b00);
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for the load/store unit.
// Little-endian: byte offset 0 is bits [7:0], a half at offset 2 is [31:16].
//
// Ports:
//   offset    in  2   byte offset within the word (address bits [1:0])
//   size      in  2   access size (lsu_pkg SIZE_* encodings)
//   ld_signed in  1   sign-extend the extracted load value
//   ld_word   in  32  word read from memory (load path)
//   ld_data   out 32  extracted and extended load value
//   st_old    in  32  word currently in memory (store path)
//   st_new    in  32  right-aligned store data
//   st_merged out 32  st_old with the addressed lane(s) replaced by st_new
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        ld_signed,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data,
    input  logic [31:0] st_old,
    input  logic [31:0] st_new,
    output logic [31:0] st_merged
);

    // ---------------------------------------------------------------
    // Load extract and extend
    // ---------------------------------------------------------------
    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        shifted  = ld_word >> {offset, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = offset[1] ? ld_word[31:16] : ld_word[15:0];
        ld_data  = ld_word;
        case (size)
            SIZE_BYTE: ld_data = {{24{ld_signed & byte_sel[7]}}, byte_sel};
            SIZE_HALF: ld_data = {{16{ld_signed & half_sel[15]}}, half_sel};
            default:   ld_data = ld_word;
        endcase
    end

    // ---------------------------------------------------------------
    // Store merge: each lane independently picks old or new data.
    // A byte store replicates st_new[7:0] onto the hit lane; a half
    // store feeds st_new[15:0] onto the lane pair chosen by offset[1].
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            logic       lane_hit;
            logic [7:0] new_lane;

            assign lane_hit = (size == SIZE_WORD)
                            || ((size == SIZE_HALF) && (offset[1] == LANE[1]))
                            || ((size == SIZE_BYTE) && (offset == LANE));

            assign new_lane = (size == SIZE_BYTE) ? st_new[7:0]
                            : (size == SIZE_HALF) ? st_new[(gi % 2) * 8 +: 8]
                            :                       st_new[gi * 8 +: 8];

            assign st_merged[gi * 8 +: 8] = lane_hit ? new_lane : st_old[gi * 8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Sits between the EX/MEM pipeline register and a word-only data memory.
// Adds byte/half loads and stores (sign or zero extension on loads) and
// alignment checking. Loads use the memory's combinational read and return
// one cycle later. Sub-word stores are a two-cycle read-modify-write; the
// pipeline is stalled during the read cycle.
//
// Ports:
//   Clk, Reset                 clock, synchronous active-high reset
//   ReqValid/ReqWrite/ReqSize/
//   ReqSigned/ReqAddr/ReqWData request from the pipeline
//   Stall                      combinational; pipeline holds Req* inputs
//   LoadData, LoadValid        registered load result and its pulse
//   AlignErr                   registered pulse for misaligned/illegal ops
//   MemAddress/MemWriteData/
//   MemWrite/MemRead           data memory request (word aligned)
//   MemReadData                data memory combinational read data
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqValid,
    input  logic              ReqWrite,
    input  logic [1:0]        ReqSize,
    input  logic              ReqSigned,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [DATA_W-1:0] ReqWData,
    output logic              Stall,
    output logic [DATA_W-1:0] LoadData,
    output logic              LoadValid,
    output logic              AlignErr,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    lsu_state_e        state_q,      state_d;
    logic [DATA_W-1:0] merge_q,      merge_d;      // merged word for RMW write
    logic [ADDR_W-1:0] rmw_addr_q,   rmw_addr_d;   // aligned address for RMW write
    logic [DATA_W-1:0] load_data_q,  load_data_d;
    logic              load_valid_q, load_valid_d;
    logic              align_err_q,  align_err_d;

    // ---------------------------------------------------------------
    // Request decode
    // ---------------------------------------------------------------
    logic [ADDR_W-1:0] aligned_addr;
    logic [1:0]        offset;
    logic              misaligned;
    logic [DATA_W-1:0] extracted;
    logic [DATA_W-1:0] merged;

    assign aligned_addr = {ReqAddr[ADDR_W-1:2], 2'b00};
    assign offset       = ReqAddr[1:0];
    assign misaligned   = is_misaligned(ReqSize, offset);

    lsu_lane_align u_lane_align (
        .offset    (offset),
        .size      (ReqSize),
        .ld_signed (ReqSigned),
        .ld_word   (MemReadData),
        .ld_data   (extracted),
        .st_old    (MemReadData),
        .st_new    (ReqWData),
        .st_merged (merged)
    );

    // ---------------------------------------------------------------
    // Next-state and memory-side outputs
    // ---------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        merge_d      = merge_q;
        rmw_addr_d   = rmw_addr_q;
        load_data_d  = load_data_q;   // LoadData holds its last result
        load_valid_d = 1'b0;
        align_err_d  = 1'b0;

        Stall        = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        MemAddress   = '0;
        MemWriteData = '0;

        case (state_q)
            ST_IDLE: begin
                if (ReqValid) begin
                    if (misaligned) begin
                        align_err_d = 1'b1;
                    end else if (!ReqWrite) begin
                        MemRead      = 1'b1;
                        MemAddress   = aligned_addr;
                        load_data_d  = extracted;
                        load_valid_d = 1'b1;
                    end else if (ReqSize == SIZE_WORD) begin
                        MemWrite     = 1'b1;
                        MemAddress   = aligned_addr;
                        MemWriteData = ReqWData;
                    end else begin
                        // Sub-word store: read the old word now, write the
                        // merged word next cycle.
                        MemRead    = 1'b1;
                        MemAddress = aligned_addr;
                        Stall      = 1'b1;
                        merge_d    = merged;
                        rmw_addr_d = aligned_addr;
                        state_d    = ST_RMW_WRITE;
                    end
                end
            end

            ST_RMW_WRITE: begin
                // Req* inputs are ignored here; the stalled store was
                // already captured.
                MemWrite     = 1'b1;
                MemAddress   = rmw_addr_q;
                MemWriteData = merge_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Reset blocks any memory access in the same cycle, so a reset
        // landing in RMW_WRITE leaves memory untouched.
        if (Reset) begin
            Stall        = 1'b0;
            MemRead      = 1'b0;
            MemWrite     = 1'b0;
            MemAddress   = '0;
            MemWriteData = '0;
        end
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            merge_q      <= '0;
            rmw_addr_q   <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            merge_q      <= merge_d;
            rmw_addr_q   <= rmw_addr_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            align_err_q  <= align_err_d;
        end
    end

    assign LoadData  = load_data_q;
    assign LoadValid = load_valid_q;
    assign AlignErr  = align_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Directed vector table, hand-written reset-during-RMW sequence and a
// randomized phase checked against a byte-array memory model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        Stall;
    logic [31:0] LoadData;
    logic        LoadValid;
    logic        AlignErr;
    logic [31:0] MemAddress;
    logic [31:0] MemWriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] MemReadData;

    always #5 Clk = ~Clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .ReqValid     (ReqValid),
        .ReqWrite     (ReqWrite),
        .ReqSize      (ReqSize),
        .ReqSigned    (ReqSigned),
        .ReqAddr      (ReqAddr),
        .ReqWData     (ReqWData),
        .Stall        (Stall),
        .LoadData     (LoadData),
        .LoadValid    (LoadValid),
        .AlignErr     (AlignErr),
        .MemAddress   (MemAddress),
        .MemWriteData (MemWriteData),
        .MemWrite     (MemWrite),
        .MemRead      (MemRead),
        .MemReadData  (MemReadData)
    );

    // ---------------- data memory (64 words, combinational read) ----------
    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic        bd_we;
    logic [5:0]  bd_idx;
    logic [31:0] bd_data;

    assign MemReadData = mem[MemAddress[7:2]];

    always @(posedge Clk) begin
        if (bd_we)         mem[bd_idx] <= bd_data;
        else if (MemWrite) mem[MemAddress[7:2]] <= MemWriteData;
    end

    // ---------------- reference model: byte-addressed memory --------------
    logic [7:0] ref_mem [0:255];

    function automatic logic [31:0] ref_word(input int a);
        int b;
        b = a - (a % 4);
        return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
    endfunction

    function automatic logic ref_err(input logic [1:0] sz, input int a);
        if (sz == 2'd3) return 1'b1;
        return (a % (1 << sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input int a, input logic [1:0] sz, input logic sg);
        int unsigned v;
        if (sz == 2'd0) begin
            v = ref_mem[a];
            if (sg && v >= 128) v = v - 256;
        end else if (sz == 2'd1) begin
            v = ref_mem[a] + 256 * ref_mem[a+1];
            if (sg && v >= 32768) v = v - 65536;
        end else begin
            v = ref_word(a);
        end
        return v;
    endfunction

    task automatic ref_store(input int a, input logic [1:0] sz, input logic [31:0] d);
        for (int i = 0; i < (1 << sz); i++) ref_mem[a+i] = 8'(d >> (8 * i));
    endtask

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One complete request, starting #1 after a posedge. exp is the load
    // result for loads and the resulting memory word for stores.
    task automatic issue(input string nm, input logic w, input logic [1:0] sz,
                         input logic sg, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp, input logic err);
        logic exp_stall, exp_rd, exp_wr;
        logic [31:0] al;
        al        = a & 32'hFFFF_FFFC;
        exp_stall = w && !err && (sz != 2'd2);
        exp_rd    = !err && (!w || sz != 2'd2);
        exp_wr    = !err && w && (sz == 2'd2);

        ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg;
        ReqAddr = a; ReqWData = d;
        #1;
        chk({nm, ".stall"},    32'(Stall),    32'(exp_stall));
        chk({nm, ".memread"},  32'(MemRead),  32'(exp_rd));
        chk({nm, ".memwrite"}, 32'(MemWrite), 32'(exp_wr));
        if (exp_rd || exp_wr) chk({nm, ".memaddr"}, MemAddress, al);
        if (exp_wr)           chk({nm, ".memwdata"}, MemWriteData, exp);

        @(posedge Clk); #1;
        chk({nm, ".alignerr"},  32'(AlignErr),  32'(err));
        chk({nm, ".loadvalid"}, 32'(LoadValid), 32'(!w && !err));
        if (!w && !err) chk({nm, ".loaddata"}, LoadData, exp);

        if (exp_stall) begin
            chk({nm, ".rmw_memwrite"}, 32'(MemWrite), 32'd1);
            chk({nm, ".rmw_memread"},  32'(MemRead),  32'd0);
            chk({nm, ".rmw_stall"},    32'(Stall),    32'd0);
            chk({nm, ".rmw_addr"},     MemAddress,    al);
            chk({nm, ".rmw_wdata"},    MemWriteData,  exp);
            @(posedge Clk); #1;
            chk({nm, ".rmw_loadvalid"}, 32'(LoadValid), 32'd0);
            chk({nm, ".rmw_alignerr"},  32'(AlignErr),  32'd0);
        end
        ReqValid = 1'b0;
        $display("txn %-8s w=%0d sz=%0d sg=%0d addr=%h wdata=%h exp=%h err=%0d ld=%h",
                 nm, w, sz, sg, a, d, exp, err, LoadData);
    endtask

    typedef struct {
        string       name;
        logic        w;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        logic        err;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"lb12",   1'b0, 2'd0, 1'b1, 32'h12, 32'h0,        32'hFFFFFF99, 1'b0};
        vecs[1]  = '{"lbu12",  1'b0, 2'd0, 1'b0, 32'h12, 32'h0,        32'h00000099, 1'b0};
        vecs[2]  = '{"lh12",   1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'hFFFF8899, 1'b0};
        vecs[3]  = '{"lhu10",  1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'h0000AABB, 1'b0};
        vecs[4]  = '{"lw10",   1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h8899AABB, 1'b0};
        vecs[5]  = '{"sb11",   1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF5A, 32'h88995ABB, 1'b0};
        vecs[6]  = '{"lw10b",  1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h88995ABB, 1'b0};
        vecs[7]  = '{"sh13",   1'b1, 2'd1, 1'b0, 32'h13, 32'h1234,     32'h0,        1'b1};
        vecs[8]  = '{"lw12",   1'b0, 2'd2, 1'b0, 32'h12, 32'h0,        32'h0,        1'b1};
        vecs[9]  = '{"ill10",  1'b0, 2'd3, 1'b0, 32'h10, 32'h0,        32'h0,        1'b1};
        vecs[10] = '{"sw20",   1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[11] = '{"lw20",   1'b0, 2'd2, 1'b0, 32'h20, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[12] = '{"lb23",   1'b0, 2'd0, 1'b1, 32'h23, 32'h0,        32'hFFFFFFDE, 1'b0};
        vecs[13] = '{"sh22",   1'b1, 2'd1, 1'b0, 32'h22, 32'h1111CAFE, 32'hCAFEBEEF, 1'b0};
        vecs[14] = '{"lh22",   1'b0, 2'd1, 1'b1, 32'h22, 32'h0,        32'hFFFFCAFE, 1'b0};

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
        ref_mem[16] = 8'hBB; ref_mem[17] = 8'hAA; ref_mem[18] = 8'h99; ref_mem[19] = 8'h88;

        ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'd0; ReqSigned = 1'b0;
        ReqAddr = '0; ReqWData = '0;
        bd_we = 1'b1; bd_idx = 6'd4; bd_data = 32'h8899AABB;
        Reset = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b0; bd_we = 1'b0;
        #1;
        chk("rst.loaddata",  LoadData,          32'h0);
        chk("rst.loadvalid", 32'(LoadValid),    32'd0);
        chk("rst.alignerr",  32'(AlignErr),     32'd0);
        chk("rst.stall",     32'(Stall),        32'd0);
        chk("rst.memwrite",  32'(MemWrite),     32'd0);
        chk("rst.memread",   32'(MemRead),      32'd0);
        @(posedge Clk); #1;
        chk("idle.memread",  32'(MemRead),      32'd0);
        chk("idle.loadvalid", 32'(LoadValid),   32'd0);

        // Reset landing in the RMW_WRITE cycle of a half store
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd1; ReqSigned = 1'b0;
        ReqAddr = 32'h10; ReqWData = 32'h1234;
        #1;
        chk("rstrmw.stall", 32'(Stall), 32'd1);
        @(posedge Clk); #1;
        Reset = 1'b1;
        #1;
        chk("rstrmw.memwrite", 32'(MemWrite), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0; ReqValid = 1'b0;
        #1;
        chk("rstrmw.after_stall",    32'(Stall),    32'd0);
        chk("rstrmw.after_memwrite", 32'(MemWrite), 32'd0);
        chk("rstrmw.mem",            mem[4],        32'h8899AABB);
        $display("txn rstrmw   sh 0x1234 to 0x10 with reset in write cycle, mem=%h", mem[4]);
        issue("lw_after_rst", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0);

        // Directed table, back-to-back
        for (int i = 0; i < 15; i++) begin
            if (!vecs[i].err && vecs[i].w) ref_store(int'(vecs[i].addr), vecs[i].sz, vecs[i].wdata);
            issue(vecs[i].name, vecs[i].w, vecs[i].sz, vecs[i].sg, vecs[i].addr,
                  vecs[i].wdata, vecs[i].exp, vecs[i].err);
        end
        @(posedge Clk); #1;
        chk("pulse_end.loadvalid", 32'(LoadValid), 32'd0);
        chk("pulse_end.alignerr",  32'(AlignErr),  32'd0);

        // Randomized phase against the byte-array model
        for (int t = 0; t < 300; t++) begin
            logic        w, sg, err;
            logic [1:0]  sz;
            logic [31:0] d, exp;
            int          a, r;
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a  = int'($urandom_range(0, 255));
            d  = $urandom;
            err = ref_err(sz, a);
            exp = 32'h0;
            if (!err && w) begin
                ref_store(a, sz, d);
                exp = ref_word(a);
            end else if (!err) begin
                exp = ref_load(a, sz, sg);
            end
            issue($sformatf("rnd%0d", t), w, sz, sg, 32'(a), d, exp, err);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge Clk); #1;
                chk("rnd_idle.loadvalid", 32'(LoadValid), 32'd0);
            end
        end

        @(posedge Clk); #1;
        for (int i = 0; i < 64; i++) chk($sformatf("final_mem%0d", i), mem[i], ref_word(i * 4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the EX/MEM pipeline register and the word-only data memory, adding MIPS sub-word accesses (lb/lbu/lh/lhu/sb/sh) and alignment checking. Loads use the memory's combinational read and return an extracted, extended value one cycle later. Sub-word stores use a two-cycle read-modify-write, because the memory writes only full 32-bit words. The block stalls the pipeline during that read-modify-write.

## Interface
Parameters:
- `ADDR_W`, 32, byte-address width.
- `DATA_W`, 32, word width; fixed at 32.

Ports:
- `Clk`  in  1  single clock; all state updates on posedge.
- `Reset`  in  1  synchronous, active-high reset.
- `ReqValid`  in  1  memory op present this cycle.
- `ReqWrite`  in  1  1 = store, 0 = load.
- `ReqSize`  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- `ReqSigned`  in  1  sign-extend on loads; ignored on stores.
- `ReqAddr`  in  32  byte address.
- `ReqWData`  in  32  store data, right-aligned (sub-word data in low bits).
- `Stall`  out  1  combinational; pipeline holds all Req* inputs this cycle.
- `LoadData`  out  32  registered load result.
- `LoadValid`  out  1  registered, one-cycle pulse per completed load.
- `AlignErr`  out  1  registered, one-cycle pulse per misaligned/illegal op.
- `MemAddress`  out  32  to data memory; bits [1:0] always 0.
- `MemWriteData`  out  32  to data memory.
- `MemWrite`  out  1  to data memory.
- `MemRead`  out  1  to data memory.
- `MemReadData`  in  32  from data memory; combinational read.

## Operation
- Byte order is little-endian: offset 0 maps to bits [7:0]; a half at offset 2 maps to bits [31:16].
- FSM states:
  - IDLE: accepts requests.
  - RMW_WRITE: writes the merged word.
- Misaligned request: half with Addr[0] = 1, word with Addr[1:0] ≠ 0, or Size = 11.
  - No MemRead and no MemWrite.
  - AlignErr = 1 next cycle; LoadValid stays 0.
  - Stall = 0.
- Load, in IDLE:
  - MemRead = 1 and MemAddress = {Addr[31:2], 2'b00}.
  - At the next edge, LoadData gets the extracted byte/half/word, sign- or zero-extended per ReqSigned, and LoadValid = 1.
  - Stall = 0.
- Word store, in IDLE:
  - MemWrite = 1 and MemWriteData = ReqWData; write completes this edge.
  - Stall = 0.
- Sub-word store:
  - In IDLE: MemRead = 1 and Stall = 1. The edge captures the merged word (MemReadData with the target lane replaced by ReqWData low bits) and the aligned address into internal registers. Next state is RMW_WRITE.
  - In RMW_WRITE: MemWrite = 1, with MemWriteData and MemAddress taken from the captured registers. Stall = 0 and the Req* inputs are ignored. Next state is IDLE.
- MemRead and MemWrite are never both 1. All Mem* outputs are 0 when no access is made.
- Reset state: IDLE; LoadData, LoadValid and AlignErr = 0; merge/address registers = 0.
- Reset asserted in RMW_WRITE: the write is suppressed, because Reset gates MemWrite combinationally. Memory is unchanged.

## Timing
- Load latency: 1 cycle, request edge to LoadValid.
- Back-to-back loads produce back-to-back LoadValid pulses.
- Word store: 1 cycle. Sub-word store: 2 cycles, with Stall high only in the first.
- A load issued the cycle after any store reads the newly written value, because the memory write lands at the preceding edge.
- LoadValid and AlignErr deassert the cycle after their pulse unless a new qualifying request arrives.
- ReqValid = 0 in IDLE: no Mem* activity and no state change.

## Structure
- Package `lsu_pkg`: the ReqSize encodings (`SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`) and the FSM state enum.
- Sub-module `lsu_lane_align`, purely combinational, with two functions:
  - load extract and extend from (word, offset, size, signed);
  - store merge from (old word, new data, offset, size).
- The top level holds the FSM, the capture registers and the output registers.

## Test plan
- Reset for 2 cycles, then idle → LoadData = 0, LoadValid = AlignErr = Stall = MemWrite = MemRead = 0.
- Memory word at 0x10 = 0x8899AABB; lb 0x12 → 0xFFFFFF99, lbu 0x12 → 0x00000099, lh 0x12 → 0xFFFF8899, lhu 0x10 → 0x0000AABB. Each result arrives one cycle later with LoadValid = 1.
- sb 0x5A to 0x11 over 0x8899AABB → Stall = 1 for one cycle, then MemWrite = 1, MemAddress = 0x10, MemWriteData = 0x88995ABB.
- sh to 0x13 and lw from 0x12 → AlignErr pulses once per request; MemRead = MemWrite = 0 throughout.
- sh 0x1234 to 0x10, with Reset asserted in the RMW_WRITE cycle → no MemWrite; word at 0x10 stays 0x8899AABB; state returns to IDLE.
- sw 0xDEADBEEF to 0x20, then lw 0x20 the next cycle → LoadData = 0xDEADBEEF with LoadValid = 1.
